encoder_8x3_pending: RTL and testbench

- Registered 8-to-3 encoder; the reverse direction of the team's 3x8 active-low decoder.
- Accepts active-low one-per-line request strobes (same polarity as decoder outputs) and latches them into a pending register.
- Serves pending requests one at a time as a binary code with a valid/ack handshake.
- Used as the request-collection end of decoder-driven select lines, such as interrupt or strobe aggregation.

---
 rtl/enc_pkg.sv | 21 ++
 rtl/prio_pick.sv | 32 +++
 rtl/encoder_8x3_pending.sv | 101 ++++++++++
 tb/tb_encoder_8x3_pending.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the pending-request 8-to-3 encoder.
// Optional feature macro: ROUND_ROBIN_EN (rotating priority instead of fixed highest-index).
package enc_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Expand a granted index into the clear mask applied to the pending register.
    function automatic logic [N_REQ-1:0] one_hot(input logic [CODE_W-1:0] idx);
        logic [N_REQ-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational priority picker: scans mask downward from 'start', wrapping
// around, and reports the first set index. Index arithmetic wraps naturally
// because N_REQ is a power of two equal to 2**CODE_W.
module prio_pick
    import enc_pkg::*;
#(
    parameter int N_REQ  = enc_pkg::N_REQ,
    parameter int CODE_W = enc_pkg::CODE_W
) (
    input  logic [N_REQ-1:0]  mask,
    input  logic [CODE_W-1:0] start,
    output logic [CODE_W-1:0] idx,
    output logic              any
);

    logic [CODE_W-1:0] pos;

    // Walk from start downward; the first set bit encountered wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = start - CODE_W'(k);
            if (!any && mask[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_8x3_pending.sv
// Registered 8-to-3 encoder with a pending-request register and valid/ack
// handshake. Active-low request strobes are latched into 'pend' and served
// one at a time as a binary code.
// Optional feature macro: ROUND_ROBIN_EN. When defined, the search starts
// just below the most recently granted index so a persistent high request
// cannot starve lower ones; otherwise the highest pending index always wins.
module encoder_8x3_pending
    import enc_pkg::*;
#(
    parameter int N_REQ  = enc_pkg::N_REQ,
    parameter int CODE_W = enc_pkg::CODE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_n,
    input  logic              en_n,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [N_REQ-1:0]  pend
);

    state_t            state;
    logic [N_REQ-1:0]  clr;
    logic [N_REQ-1:0]  set;
    logic [CODE_W-1:0] pick_start;
    logic [CODE_W-1:0] pick_idx;
    logic              pick_any;

`ifdef ROUND_ROBIN_EN
    logic [CODE_W-1:0] last;

    // Rotating start point: one below the last granted index, wrapping.
    assign pick_start = last - CODE_W'(1);
`else
    // Fixed priority: always start the search at the top index.
    assign pick_start = CODE_W'(N_REQ - 1);
`endif

    // The granted bit is cleared only in the accepting cycle; new requests are
    // captured only while the active-low enable is asserted.
    assign clr = (valid && ack) ? one_hot(code) : '0;
    assign set = ~req_n & {N_REQ{~en_n}};

    prio_pick #(
        .N_REQ  (N_REQ),
        .CODE_W (CODE_W)
    ) u_pick (
        .mask  (pend),
        .start (pick_start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Pending register: set wins over clear so a re-request in the ack cycle survives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr) | set;
        end
    end

    // Grant FSM with registered code/valid; one idle cycle separates grants.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            code  <= '0;
            valid <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        code  <= pick_idx;
                        valid <= 1'b1;
                        state <= GRANT;
                    end else begin
                        valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        valid <= 1'b0;
                        state <= IDLE;
`ifdef ROUND_ROBIN_EN
                        last  <= code;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encoder_8x3_pending.sv
// Directed self-checking bench for encoder_8x3_pending.
// Builds with or without ROUND_ROBIN_EN; expectations follow the macro.
module tb_encoder_8x3_pending;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_n;
    logic       en_n;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pend;

    int passCount;
    int checkCount;

    encoder_8x3_pending dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req_n (req_n),
        .en_n  (en_n),
        .ack   (ack),
        .code  (code),
        .valid (valid),
        .pend  (pend)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and tally it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Set the inputs seen at the next rising edge, then advance past that edge.
    task automatic applyStimulus(input logic r, input logic [7:0] rq, input logic e, input logic a);
        rst_n = r;
        req_n = rq;
        en_n  = e;
        ack   = a;
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles followed by one quiet cycle.
    task automatic applyReset();
        applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    endtask

    logic [2:0] expCodes [4];
    logic [7:0] expPends [4];
    logic [2:0] rrCodes  [4];

    initial begin
        passCount  = 0;
        checkCount = 0;
        rst_n = 1'b0;
        req_n = 8'hFF;
        en_n  = 1'b0;
        ack   = 1'b0;

        // Reset with all requests active: nothing may be captured.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("reset_pend", 32'(pend), 32'h00);
        checkOutput("reset_valid", 32'(valid), 32'h0);
        checkOutput("reset_code", 32'(code), 32'h0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("post_reset_pend", 32'(pend), 32'h00);

        // Single request on index 5.
        applyStimulus(1'b1, 8'hDF, 1'b0, 1'b0);
        checkOutput("single_pend", 32'(pend), 32'h20);
        checkOutput("single_valid_lag", 32'(valid), 32'h0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("single_valid", 32'(valid), 32'h1);
        checkOutput("single_code", 32'(code), 32'h5);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("single_hold_valid", 32'(valid), 32'h1);
        checkOutput("single_hold_code", 32'(code), 32'h5);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
        checkOutput("single_ack_pend", 32'(pend), 32'h00);
        checkOutput("single_ack_valid", 32'(valid), 32'h0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
        checkOutput("stray_ack_valid", 32'(valid), 32'h0);
        checkOutput("stray_ack_pend", 32'(pend), 32'h00);

        // Multiple requests served in priority order with ack held high.
        applyReset();
        expCodes = '{3'd7, 3'd5, 3'd2, 3'd0};
        expPends = '{8'h25, 8'h05, 8'h01, 8'h00};
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
        checkOutput("multi_pend", 32'(pend), 32'hA5);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
            checkOutput($sformatf("multi_valid_%0d", i), 32'(valid), 32'h1);
            checkOutput($sformatf("multi_code_%0d", i), 32'(code), 32'(expCodes[i]));
            applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
            checkOutput($sformatf("multi_gap_%0d", i), 32'(valid), 32'h0);
            checkOutput($sformatf("multi_pend_%0d", i), 32'(pend), 32'(expPends[i]));
        end

        // Enable gating: requests ignored while en_n is high.
        applyReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("gate_pend", 32'(pend), 32'h00);
        checkOutput("gate_valid", 32'(valid), 32'h0);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
        checkOutput("ungate_pend", 32'(pend), 32'hFF);

        // Set wins over clear on a re-request in the ack cycle.
        applyReset();
        applyStimulus(1'b1, 8'hF7, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("setwin_code", 32'(code), 32'h3);
        checkOutput("setwin_valid", 32'(valid), 32'h1);
        applyStimulus(1'b1, 8'hF7, 1'b0, 1'b1);
        checkOutput("setwin_pend", 32'(pend), 32'h08);
        checkOutput("setwin_gap", 32'(valid), 32'h0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("setwin_regrant_valid", 32'(valid), 32'h1);
        checkOutput("setwin_regrant_code", 32'(code), 32'h3);

        // Continuous requests on 7 and 0 with ack held high.
        applyReset();
`ifdef ROUND_ROBIN_EN
        rrCodes = '{3'd7, 3'd0, 3'd7, 3'd0};
`else
        rrCodes = '{3'd7, 3'd7, 3'd7, 3'd7};
`endif
        applyStimulus(1'b1, 8'h7E, 1'b0, 1'b1);
        checkOutput("rr_pend", 32'(pend), 32'h81);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'h7E, 1'b0, 1'b1);
            checkOutput($sformatf("rr_valid_%0d", i), 32'(valid), 32'h1);
            checkOutput($sformatf("rr_code_%0d", i), 32'(code), 32'(rrCodes[i]));
            if (i < 3) begin
                applyStimulus(1'b1, 8'h7E, 1'b0, 1'b1);
                checkOutput($sformatf("rr_gap_%0d", i), 32'(valid), 32'h0);
            end
        end

        // Reset while a grant is outstanding.
        applyStimulus(1'b0, 8'h7E, 1'b0, 1'b1);
        checkOutput("midreset_valid", 32'(valid), 32'h0);
        checkOutput("midreset_pend", 32'(pend), 32'h00);
        checkOutput("midreset_code", 32'(code), 32'h0);
        applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
        checkOutput("midreset_idle_valid", 32'(valid), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
